// File: rtl/cfg_frame_loader.sv
// rtl/cfg_frame_loader.sv - framed byte-stream loader for the 32-bit config register
//
// Accepts a byte stream (HEADER, k1, k2, k3, ctrl, XOR checksum), assembles
// the word {k1, k2, k3, ctrl} and writes it to the config register with a
// one-cycle strobe. The write is held until the datapath reports idle.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   in_valid   in   byte offered on in_data
//   in_data    in   [7:0] offered byte
//   in_ready   out  byte can be accepted (low only while a commit is pending)
//   sys_idle   in   encrypt/decrypt units have nothing in flight
//   cfg_wen    out  one-cycle config write strobe
//   cfg_data   out  [31:0] last committed config word
//   frame_ok   out  one-cycle pulse with cfg_wen
//   err        out  one-cycle pulse when a frame is aborted
//   err_code   out  [1:0] cause of last abort: 01 checksum, 10 timeout

module cfg_frame_loader #(
   parameter logic [7:0]  HEADER  = 8'hA5,
   parameter logic [15:0] TIMEOUT = 16'd1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   input  logic        sys_idle,
   output logic        cfg_wen,
   output logic [31:0] cfg_data,
   output logic        frame_ok,
   output logic        err,
   output logic [1:0]  err_code
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_CHK    = 2'd2,
      S_COMMIT = 2'd3
   } state_t;

   state_t      state, state_nxt;
   logic [1:0]  idx;
   logic [7:0]  chk;
   logic [31:0] shadow;
   logic [15:0] cnt;

   logic accept;
   logic in_frame;
   logic tmo;
   logic chk_bad;
   logic commit;

   assign in_ready = (state != S_COMMIT);
   assign accept   = in_valid && in_ready;
   assign in_frame = (state == S_DATA) || (state == S_CHK);

   // The counter reaches TIMEOUT on this edge; an accepted byte wins over it.
   assign tmo      = in_frame && !accept && (cnt == TIMEOUT - 16'd1);
   assign chk_bad  = (state == S_CHK) && accept && (in_data != chk);
   assign commit   = (state == S_COMMIT) && sys_idle;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept && in_data == HEADER) state_nxt = S_DATA;
         end
         S_DATA: begin
            if (accept && idx == 2'd3) state_nxt = S_CHK;
            else if (tmo)              state_nxt = S_IDLE;
         end
         S_CHK: begin
            if (accept)   state_nxt = (in_data == chk) ? S_COMMIT : S_IDLE;
            else if (tmo) state_nxt = S_IDLE;
         end
         S_COMMIT: begin
            if (sys_idle) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx      <= 2'd0;
         chk      <= 8'h00;
         shadow   <= 32'h0000_0000;
         cnt      <= 16'd0;
         cfg_wen  <= 1'b0;
         frame_ok <= 1'b0;
         err      <= 1'b0;
         err_code <= 2'b00;
         cfg_data <= 32'h0000_0000;
      end else begin
         cfg_wen  <= commit;
         frame_ok <= commit;
         err      <= chk_bad || tmo;

         if (chk_bad)  err_code <= 2'b01;
         else if (tmo) err_code <= 2'b10;

         if (commit) cfg_data <= shadow;

         if (state == S_IDLE && accept && in_data == HEADER) begin
            idx <= 2'd0;
            chk <= 8'h00;
         end else if (state == S_DATA && accept) begin
            // Base bit 31-8*idx, i.e. {~idx, 3'b111}: payload lands MSB-first.
            shadow[{~idx, 3'b111} -: 8] <= in_data;
            chk <= chk ^ in_data;
            idx <= idx + 2'd1;
         end

         // Runs only inside a frame; any accepted byte restarts it, and the
         // IDLE clear covers entry into DATA.
         if (!in_frame || accept || tmo) cnt <= 16'd0;
         else                            cnt <= cnt + 16'd1;
      end
   end

endmodule
